// File: rtl/soc_obi_pkg.sv
// Shared OBI request/response types for the SoC data-side interconnect.
package soc_obi_pkg;

  localparam int OBI_AW = 32;

  typedef struct packed {
    logic              req;
    logic [OBI_AW-1:0] addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_rsp_t;

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of master indices, one entry per accepted-but-unanswered transaction.
module obi_id_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic [W-1:0]           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_d_obi_arbiter.sv
// Round-robin N-to-1 OBI arbiter feeding the SRAM data port; responses are
// steered back to their issuing master through an in-order owner FIFO.
module sram_d_obi_arbiter
  import soc_obi_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int IDX_W           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_MASTERS-1:0]      m_req_i,
  output logic [NUM_MASTERS-1:0]      m_gnt_o,
  input  logic [NUM_MASTERS*32-1:0]   m_addr_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*4-1:0]    m_be_i,
  input  logic [NUM_MASTERS*32-1:0]   m_wdata_i,
  output logic [NUM_MASTERS-1:0]      m_rvalid_o,
  output logic [NUM_MASTERS*32-1:0]   m_rdata_o,
  output logic                        s_req_o,
  input  logic                        s_gnt_i,
  output logic [31:0]                 s_addr_o,
  output logic                        s_we_o,
  output logic [3:0]                  s_be_o,
  output logic [31:0]                 s_wdata_o,
  input  logic                        s_rvalid_i,
  input  logic [31:0]                 s_rdata_i,
  output logic                        resp_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [OBI_AW-1:0] addr_a  [NUM_MASTERS];
  logic [31:0]       wdata_a [NUM_MASTERS];
  logic [3:0]        be_a    [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_a[g]  = m_addr_i[g*32 +: 32];
    assign wdata_a[g] = m_wdata_i[g*32 +: 32];
    assign be_a[g]    = m_be_i[g*4 +: 4];
  end

  logic [IDX_W-1:0] rr_ptr, win_idx, cand, head_idx;
  logic             found;
  int               sum;
  obi_req_t         win;
  logic             can_issue, hs, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Scan from the round-robin pointer; first requester wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    sum     = 0;
    win     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      sum = int'(rr_ptr) + i;
      if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
      cand = IDX_W'(sum);
      if (!found && m_req_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    if (found) begin
      win.req   = 1'b1;
      win.addr  = addr_a[win_idx];
      win.we    = m_we_i[win_idx];
      win.be    = be_a[win_idx];
      win.wdata = wdata_a[win_idx];
    end
  end

  // Gate uses the registered count only, so rvalid never reaches the grant combinationally.
  assign can_issue = (fifo_count < CNT_W'(MAX_OUTSTANDING));
  assign s_req_o   = rst_ni & can_issue & win.req;
  assign hs        = s_req_o & s_gnt_i;
  assign s_addr_o  = win.addr;
  assign s_we_o    = win.we;
  assign s_be_o    = win.be;
  assign s_wdata_o = win.wdata;

  assign pop       = rst_ni & s_rvalid_i & ~fifo_empty;
  assign m_rdata_o = {NUM_MASTERS{s_rdata_i}};

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (hs)  m_gnt_o[win_idx]     = 1'b1;
    if (pop) m_rvalid_o[head_idx] = 1'b1;
  end

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDX_W)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs & ~fifo_full),
    .data_i  (win_idx),
    .pop_i   (pop),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      resp_err_o <= 1'b0;
    end else begin
      if (hs) rr_ptr <= (win_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
      if (s_rvalid_i && fifo_empty) resp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_d_obi_arbiter.sv
// Directed scoreboard bench for sram_d_obi_arbiter (2 masters, 2 outstanding).
module tb_sram_d_obi_arbiter;

  localparam int NM = 2;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [NM-1:0]     m_req_i;
  logic [NM-1:0]     m_gnt_o;
  logic [NM*32-1:0]  m_addr_i;
  logic [NM-1:0]     m_we_i;
  logic [NM*4-1:0]   m_be_i;
  logic [NM*32-1:0]  m_wdata_i;
  logic [NM-1:0]     m_rvalid_o;
  logic [NM*32-1:0]  m_rdata_o;
  logic              s_req_o;
  logic              s_gnt_i;
  logic [31:0]       s_addr_o;
  logic              s_we_o;
  logic [3:0]        s_be_o;
  logic [31:0]       s_wdata_o;
  logic              s_rvalid_i;
  logic [31:0]       s_rdata_i;
  logic              resp_err_o;

  sram_d_obi_arbiter #(.NUM_MASTERS(NM), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .resp_err_o(resp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          mst;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input int m, input logic [31:0] d);
    exp_t e;
    e.mst = m;
    e.rdata = d;
    exp_q.push_back(e);
  endtask

  task automatic set_m(input int m, input logic req, input logic [31:0] addr,
                       input logic we, input logic [3:0] be, input logic [31:0] wd);
    m_req_i[m]          = req;
    m_addr_i[m*32 +: 32] = addr;
    m_we_i[m]           = we;
    m_be_i[m*4 +: 4]    = be;
    m_wdata_i[m*32 +: 32] = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  // Response monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < NM; i++) begin
      if (m_rvalid_o[i] === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rvalid_unexpected: master %0d got rvalid, none expected at %0t", i, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.mst != i || m_rdata_o[i*32 +: 32] !== e.rdata) begin
            miscompares++;
            $display("FAIL rsp_route: got master %0d rdata %h expected master %0d rdata %h at %0t",
                     i, m_rdata_o[i*32 +: 32], e.mst, e.rdata, $time);
          end
        end
      end
    end
  end

  initial begin
    int iss[NM];
    int w;
    rst_ni = 1'b0;
    clear_inputs();

    // Reset state with requests, grant and rvalid all asserted
    m_req_i = 2'b11; s_gnt_i = 1'b1; s_rvalid_i = 1'b1;
    settle();
    chk("rst_s_req", {31'b0, s_req_o}, 32'd0);
    chk("rst_m_gnt", {30'b0, m_gnt_o}, 32'd0);
    chk("rst_m_rvalid", {30'b0, m_rvalid_o}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err_o}, 32'd0);
    do_reset();

    // Single master back-to-back reads
    set_m(0, 1'b1, 32'h8000_0004, 1'b0, 4'hF, 32'h0); s_gnt_i = 1'b1;
    expect_rsp(0, 32'h1111_0004);
    settle();
    chk("t1_req_a", {31'b0, s_req_o}, 32'd1);
    chk("t1_addr_a", s_addr_o, 32'h8000_0004);
    chk("t1_gnt_a", {30'b0, m_gnt_o}, 32'd1);
    tick();
    set_m(0, 1'b1, 32'h8000_0008, 1'b0, 4'hF, 32'h0);
    s_rvalid_i = 1'b1; s_rdata_i = 32'h1111_0004;
    expect_rsp(0, 32'h1111_0008);
    settle();
    chk("t1_req_b", {31'b0, s_req_o}, 32'd1);
    chk("t1_addr_b", s_addr_o, 32'h8000_0008);
    chk("t1_gnt_b", {30'b0, m_gnt_o}, 32'd1);
    tick();
    m_req_i = '0; s_rdata_i = 32'h1111_0008;
    settle();
    chk("t1_req_idle", {31'b0, s_req_o}, 32'd0);
    chk("t1_addr_idle", s_addr_o, 32'd0);
    tick();
    s_rvalid_i = 1'b0;
    settle();
    chk("t1_resp_err", {31'b0, resp_err_o}, 32'd0);
    tick();

    // Contention: alternating grants starting at m0
    do_reset();
    iss[0] = 0; iss[1] = 0;
    s_gnt_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = k % 2;
      for (int m = 0; m < NM; m++)
        set_m(m, iss[m] < 4, 32'h1000_0000 + m * 32'h100 + iss[m] * 4, 1'b0, 4'hF, 32'h0);
      s_rvalid_i = (k > 0);
      s_rdata_i  = 32'hA000_0000 + k - 1;
      expect_rsp(w, 32'hA000_0000 + k);
      settle();
      chk("t2_gnt", {30'b0, m_gnt_o}, 32'd1 << w);
      chk("t2_addr", s_addr_o, 32'h1000_0000 + w * 32'h100 + (k / 2) * 4);
      tick();
      iss[w]++;
    end
    m_req_i = '0; s_rvalid_i = 1'b1; s_rdata_i = 32'hA000_0007;
    tick();
    s_rvalid_i = 1'b0;

    // Back-pressure on a write from m1 while m0 also waits
    do_reset();
    set_m(0, 1'b1, 32'h0000_2000, 1'b0, 4'hF, 32'h0); s_gnt_i = 1'b1;
    expect_rsp(0, 32'hD000_0000);
    settle();
    chk("t3_gnt_c0", {30'b0, m_gnt_o}, 32'd1);
    tick();
    set_m(0, 1'b1, 32'h0000_2004, 1'b0, 4'hF, 32'h0);
    set_m(1, 1'b1, 32'h0000_3000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
    s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hD000_0000;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t3_stall_req", {31'b0, s_req_o}, 32'd1);
      chk("t3_stall_gnt", {30'b0, m_gnt_o}, 32'd0);
      chk("t3_stall_addr", s_addr_o, 32'h0000_3000);
      chk("t3_stall_we", {31'b0, s_we_o}, 32'd1);
      chk("t3_stall_be", {28'b0, s_be_o}, 32'h3);
      chk("t3_stall_wdata", s_wdata_o, 32'hDEAD_BEEF);
      tick();
      s_rvalid_i = 1'b0;
    end
    s_gnt_i = 1'b1;
    expect_rsp(1, 32'hD000_0001);
    settle();
    chk("t3_gnt_m1", {30'b0, m_gnt_o}, 32'd2);
    tick();
    set_m(1, 1'b1, 32'h0000_3004, 1'b0, 4'hF, 32'h0);
    s_rvalid_i = 1'b1; s_rdata_i = 32'hD000_0001;
    expect_rsp(0, 32'hD000_0002);
    settle();
    chk("t3_gnt_m0_after", {30'b0, m_gnt_o}, 32'd1);
    chk("t3_addr_m0_after", s_addr_o, 32'h0000_2004);
    tick();
    m_req_i[0] = 1'b0; s_rdata_i = 32'hD000_0002;
    expect_rsp(1, 32'hD000_0003);
    settle();
    chk("t3_gnt_m1_next", {30'b0, m_gnt_o}, 32'd2);
    chk("t3_addr_m1_next", s_addr_o, 32'h0000_3004);
    tick();
    m_req_i = '0; s_rdata_i = 32'hD000_0003;
    tick();
    s_rvalid_i = 1'b0;

    // Full: two outstanding, slave withholds rvalid
    do_reset();
    set_m(0, 1'b1, 32'h0000_4000, 1'b0, 4'hF, 32'h0); s_gnt_i = 1'b1;
    expect_rsp(0, 32'hE000_0000);
    settle();
    chk("t4_gnt_c0", {30'b0, m_gnt_o}, 32'd1);
    tick();
    m_req_i[0] = 1'b0;
    set_m(1, 1'b1, 32'h0000_5000, 1'b0, 4'hF, 32'h0);
    expect_rsp(1, 32'hE000_0001);
    settle();
    chk("t4_gnt_c1", {30'b0, m_gnt_o}, 32'd2);
    tick();
    m_req_i[1] = 1'b0;
    set_m(0, 1'b1, 32'h0000_4004, 1'b0, 4'hF, 32'h0);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("t4_full_req", {31'b0, s_req_o}, 32'd0);
      chk("t4_full_gnt", {30'b0, m_gnt_o}, 32'd0);
      tick();
    end
    s_rvalid_i = 1'b1; s_rdata_i = 32'hE000_0000;
    settle();
    chk("t4_pop_cycle_req", {31'b0, s_req_o}, 32'd0);
    tick();
    s_rdata_i = 32'hE000_0001;
    expect_rsp(0, 32'hE000_0002);
    settle();
    chk("t4_resume_req", {31'b0, s_req_o}, 32'd1);
    chk("t4_resume_gnt", {30'b0, m_gnt_o}, 32'd1);
    chk("t4_resume_addr", s_addr_o, 32'h0000_4004);
    tick();
    m_req_i = '0; s_rdata_i = 32'hE000_0002;
    tick();
    s_rvalid_i = 1'b0;

    // Spurious response with the owner FIFO empty
    s_rvalid_i = 1'b1; s_rdata_i = 32'h5555_5555;
    settle();
    chk("t5_err_before", {31'b0, resp_err_o}, 32'd0);
    tick();
    s_rvalid_i = 1'b0;
    settle();
    chk("t5_err_set", {31'b0, resp_err_o}, 32'd1);
    tick();
    set_m(0, 1'b1, 32'h0000_6000, 1'b0, 4'hF, 32'h0);
    expect_rsp(0, 32'hF000_0000);
    settle();
    chk("t5_err_held", {31'b0, resp_err_o}, 32'd1);
    chk("t5_req_c2", {31'b0, s_req_o}, 32'd1);
    chk("t5_gnt_c2", {30'b0, m_gnt_o}, 32'd1);
    tick();
    m_req_i[0] = 1'b0;
    set_m(1, 1'b1, 32'h0000_6100, 1'b0, 4'hF, 32'h0);
    expect_rsp(1, 32'hF000_0001);
    settle();
    chk("t5_req_c3", {31'b0, s_req_o}, 32'd1);
    chk("t5_gnt_c3", {30'b0, m_gnt_o}, 32'd2);
    tick();
    m_req_i = '0; s_rvalid_i = 1'b1; s_rdata_i = 32'hF000_0000;
    settle();
    chk("t5_idle_req", {31'b0, s_req_o}, 32'd0);
    tick();
    s_rdata_i = 32'hF000_0001;
    tick();
    s_rvalid_i = 1'b0;

    // Async reset with two outstanding transactions
    do_reset();
    settle();
    chk("t6_err_cleared", {31'b0, resp_err_o}, 32'd0);
    tick();
    set_m(0, 1'b1, 32'h0000_7000, 1'b0, 4'hF, 32'h0); s_gnt_i = 1'b1;
    settle();
    chk("t6_gnt_c0", {30'b0, m_gnt_o}, 32'd1);
    tick();
    set_m(0, 1'b1, 32'h0000_7004, 1'b0, 4'hF, 32'h0);
    settle();
    chk("t6_gnt_c1", {30'b0, m_gnt_o}, 32'd1);
    tick();
    set_m(0, 1'b1, 32'h0000_7008, 1'b0, 4'hF, 32'h0);
    set_m(1, 1'b1, 32'h0000_7100, 1'b0, 4'hF, 32'h0);
    settle();
    chk("t6_full_req", {31'b0, s_req_o}, 32'd0);
    #2;
    rst_ni = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hBAD0_0000;
    #1;
    chk("t6_rst_s_req", {31'b0, s_req_o}, 32'd0);
    chk("t6_rst_m_gnt", {30'b0, m_gnt_o}, 32'd0);
    chk("t6_rst_m_rvalid", {30'b0, m_rvalid_o}, 32'd0);
    chk("t6_rst_resp_err", {31'b0, resp_err_o}, 32'd0);
    tick();
    rst_ni = 1'b1; s_gnt_i = 1'b0; s_rvalid_i = 1'b0;
    settle();
    chk("t6_post_req", {31'b0, s_req_o}, 32'd1);
    chk("t6_post_addr_m0", s_addr_o, 32'h0000_7008);
    tick();
    m_req_i = '0; s_rvalid_i = 1'b1; s_rdata_i = 32'hBAD0_0001;
    settle();
    chk("t6_late_rvalid", {30'b0, m_rvalid_o}, 32'd0);
    tick();
    s_rvalid_i = 1'b0;
    settle();
    chk("t6_late_err", {31'b0, resp_err_o}, 32'd1);
    tick();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_d_obi_arbiter.md
Name: sram_d_obi_arbiter

Overview:
- N-to-1 OBI arbiter/mux that produces the muxed data-side SRAM request stream consumed by the SRAM wrapper's sram_d port.
- Merges the core data port, DMA and debug master onto one slave port using round-robin arbitration.
- Tracks the owner of each issued transaction in an in-order FIFO and routes every slave rvalid/rdata back to the master that issued it.

Parameters:
- NUM_MASTERS, 2, number of upstream OBI masters (2..4).
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered slave transactions; depth of the owner FIFO (power of 2, ≥1).
- IDX_W, $clog2(NUM_MASTERS) (minimum 1), width of a master index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m_req_i  in  NUM_MASTERS  per-master request
- m_gnt_o  out  NUM_MASTERS  per-master grant
- m_addr_i  in  NUM_MASTERS×32  per-master byte address
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_be_i  in  NUM_MASTERS×4  per-master byte enables
- m_wdata_i  in  NUM_MASTERS×32  per-master write data
- m_rvalid_o  out  NUM_MASTERS  per-master response valid
- m_rdata_o  out  NUM_MASTERS×32  per-master read data (rdata broadcast to all masters; only the qualified one is meaningful)
- s_req_o  out  1  slave request (to sram_d_req_i)
- s_gnt_i  in  1  slave grant
- s_addr_o  out  32  slave address
- s_we_o  out  1  slave write enable
- s_be_o  out  4  slave byte enables
- s_wdata_o  out  32  slave write data
- s_rvalid_i  in  1  slave response valid
- s_rdata_i  in  32  slave read data
- resp_err_o  out  1  sticky: rvalid received with the owner FIFO empty

Behaviour:
- Reset (rst_ni=0, async):
  - RR pointer=0, FIFO empty, count=0, resp_err_o=0.
  - All m_gnt_o, m_rvalid_o and s_req_o read 0.
- Issue gate: `can_issue = (count < MAX_OUTSTANDING)`, from registered count only. There is no combinational path from s_rvalid_i to the grant.
- Arbitration (combinational):
  - Scan masters starting at the RR pointer, wrapping modulo NUM_MASTERS; the first asserted m_req_i wins.
  - `s_req_o = can_issue & |m_req_i`.
  - Winner's addr/we/be/wdata are muxed onto the s_* outputs. When there is no winner, s_* payload = 0.
  - `m_gnt_o[w] = s_gnt_i & s_req_o`; all other grants 0.
- Handshake accepted (s_req_o & s_gnt_i):
  - Push the winner index into the FIFO.
  - RR pointer ← (w+1) mod NUM_MASTERS.
  - With no handshake, the pointer holds.
- Masters must hold req and payload stable until granted (OBI rule). A losing master simply keeps requesting.
- Response (s_rvalid_i):
  - Pop the FIFO head h; `m_rvalid_o[h]=1` in the same cycle (combinational from s_rvalid_i).
  - m_rdata_o = s_rdata_i for all masters.
  - Writes also produce rvalid, and it is routed identically.
- Simultaneous push and pop in one cycle: count unchanged; both pointers advance. Legal even when count==MAX_OUTSTANDING, though with a registered gate no push occurs at full.
- Full (count==MAX_OUTSTANDING): s_req_o=0 and all m_gnt_o=0 until a pop lowers count. The first issue after a pop happens in the next cycle.
- rvalid with FIFO empty:
  - No master gets rvalid and the FIFO does not underflow (pointers/count unchanged).
  - resp_err_o←1 and stays 1 until reset.
- Latency: zero-cycle request path. Responses return with the slave's latency (1 cycle for the SRAM wrapper), so back-to-back single-cycle transactions sustain 1/cycle with MAX_OUTSTANDING≥2.
- Reset mid-operation: outstanding transactions are discarded. Responses arriving after reset release hit an empty FIFO and set resp_err_o.
- Pointer arithmetic wraps on IDX_W+1-bit count / IDX-sized pointers. MAX_OUTSTANDING=1 must still work, with 50% throughput.

Decomposition:
- Shared package soc_obi_pkg:
  - obi_req_t {req, addr[31:0], we, be[3:0], wdata[31:0]}
  - obi_rsp_t {gnt, rvalid, rdata[31:0]}
  - constant OBI_AW=32
- One sub-module, obi_id_fifo: a parameterised DEPTH×IDX_W in-order FIFO with push/pop, full/empty and count. This is the only sequential storage besides the RR pointer and the error flag.

Test Plan:
- Single master, 2 masters, slave gnt=1, 1-cycle rvalid: m0 reads 0x8000_0004 then 0x8000_0008 back-to-back → s_req_o high 2 cycles, m_rvalid_o[0] on cycles 2 and 3 with correct rdata, m_rvalid_o[1] never.
- Contention: m0 and m1 both request continuously, 4 transactions each → grants alternate m0,m1,m0,m1… starting with m0 after reset; every rvalid goes to the issuing master in issue order.
- Back-pressure: s_gnt_i=0 for 3 cycles while m1 requests write be=4'b0011 wdata=0xDEAD_BEEF → s_* payload stable for 3 cycles, m_gnt_o=0, and RR pointer unchanged. When gnt rises, exactly one handshake occurs and the pointer moves to 0.
- Full: MAX_OUTSTANDING=2, slave withholds rvalid for 4 cycles after 2 grants → s_req_o=0 while count=2. After one rvalid, issue resumes the following cycle.
- Spurious response: s_rvalid_i pulse with FIFO empty → no m_rvalid_o, resp_err_o=1 and held; FIFO count remains 0.
- Async reset asserted with 2 outstanding → outputs 0 immediately. After release, the first arbitration starts at m0 and a late rvalid sets resp_err_o.
